// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the fetch stage and the
// memory stage. Each access is sequenced IDLE -> ISSUE -> WAIT -> RESP, so an
// access takes 3 + MEM_LATENCY cycles. Data requests win arbitration, but a
// burst counter forces a fetch grant after MAX_DATA_BURST consecutive data
// grants while fetch is waiting. A fetch flush drops the stale fetch result
// without disturbing the memory access already under way.

module mem_port_arbiter #(
    parameter int WIDTH          = 32,
    parameter int MEM_LATENCY    = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,

    // Fetch stage port (read only)
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    input  logic             if_flush,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ready,

    // Memory stage port (loads and stores)
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_ready,

    // Unified memory port
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,

    // Pipeline stall requests
    output logic             stall_f,
    output logic             stall_m
);

    // Counter widths: the latency counter holds 0..MEM_LATENCY, the burst
    // counter holds 0..MAX_DATA_BURST (it saturates at the top value).
    localparam int CNT_W   = (MEM_LATENCY    < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam int BURST_W = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);

    localparam logic [CNT_W-1:0]   LAT_LOAD  = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0]   LAT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        SRC_DATA  = 1'b0,
        SRC_FETCH = 1'b1
    } src_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;

    src_t               r_src;        // winner of the last arbitration
    logic               r_we;         // latched write enable of the winner
    logic [WIDTH-1:0]   r_addr;       // latched address of the winner
    logic [WIDTH-1:0]   r_wdata;      // latched store data of the winner
    logic [CNT_W-1:0]   r_lat_cnt;    // remaining memory latency cycles
    logic [BURST_W-1:0] r_burst;      // data grants made while fetch waited
    logic               r_drop;       // in-flight fetch was flushed
    logic [WIDTH-1:0]   r_if_rdata;   // last fetched instruction
    logic [WIDTH-1:0]   r_dm_rdata;   // last loaded data word

    // ------------------------------------------------------------------
    // Arbitration (only acted upon in IDLE)
    // ------------------------------------------------------------------
    logic w_if_eligible;
    logic w_burst_full;
    logic w_grant_fetch;
    logic w_grant_data;
    logic w_capture;
    logic w_in_flight;

    // A flushed fetch request is stale, so it may not compete this cycle.
    assign w_if_eligible = if_req & ~if_flush;
    assign w_burst_full  = (r_burst == BURST_MAX);

    // Data wins a tie unless fetch has already waited through a full burst.
    assign w_grant_fetch = (r_state == ST_IDLE) & w_if_eligible & (~dm_req | w_burst_full);
    assign w_grant_data  = (r_state == ST_IDLE) & dm_req & ~w_grant_fetch;

    // Any state past arbitration belongs to the latched transaction.
    assign w_in_flight   = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // Advance the access sequencer; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // always_ff samples the pre-edge values of its neighbours.
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and strobe decode
    // ------------------------------------------------------------------
    // Decode the next state and the per-state strobes from the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        w_state_next = r_state;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        if_ready     = 1'b0;
        dm_ready     = 1'b0;
        w_capture    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_fetch || w_grant_data) begin
                    w_state_next = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                mem_en       = 1'b1;
                mem_we       = r_we;
                w_state_next = ST_WAIT;
            end

            ST_WAIT: begin
                // The counter reaches zero on this cycle: read data is valid.
                if (r_lat_cnt <= LAT_ONE) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end

            ST_RESP: begin
                // A flush landing in RESP kills the pulse in the same cycle.
                if_ready     = (r_src == SRC_FETCH) & ~r_drop & ~if_flush;
                dm_ready     = (r_src == SRC_DATA);
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    // Capture the winner's address, write enable and store data in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src   <= SRC_DATA;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_fetch) begin
            r_src   <= SRC_FETCH;
            r_we    <= 1'b0;
            r_addr  <= if_addr;
            r_wdata <= '0;
        end else if (w_grant_data) begin
            r_src   <= SRC_DATA;
            r_we    <= dm_we;
            r_addr  <= dm_addr;
            r_wdata <= dm_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Latency counter
    // ------------------------------------------------------------------
    // Load the memory latency on issue and count it down while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_lat_cnt <= LAT_LOAD;
        end else if (r_state == ST_WAIT && r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - LAT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Starvation (burst) counter
    // ------------------------------------------------------------------
    // Count data grants that beat a waiting fetch; clear once fetch is served
    // or stops asking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_fetch || !if_req) begin
                r_burst <= '0;
            end else if (w_grant_data && !w_burst_full) begin
                r_burst <= r_burst + BURST_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch drop flag
    // ------------------------------------------------------------------
    // Remember a flush that hits an in-flight fetch so its ready is withheld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (!w_in_flight) begin
            r_drop <= 1'b0;
        end else if (r_src == SRC_FETCH && if_flush) begin
            r_drop <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read data registers
    // ------------------------------------------------------------------
    // Capture memory read data into the winner's register; stores leave the
    // load register untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_capture) begin
            if (r_src == SRC_FETCH) begin
                r_if_rdata <= mem_rdata;
            end else if (!r_we) begin
                r_dm_rdata <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    // Address and store data stay on the latched values; mem_we is already
    // qualified by mem_en in the FSM decode.
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

    // Each stage stalls while it has an outstanding, uncompleted request.
    assign stall_f   = if_req & ~if_ready;
    assign stall_m   = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Two arbiter instances share clock and reset: u_dut with MEM_LATENCY=1 and
// u_dut3 with MEM_LATENCY=3. A behavioural memory per instance returns the
// real word only in the cycle the data is due and garbage otherwise. Expected
// read data is queued when a request is driven and popped on every ready.

`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] GARBAGE = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Instance A signals (MEM_LATENCY = 1)
    // ------------------------------------------------------------------
    logic             if_req, if_flush, if_ready;
    logic [WIDTH-1:0] if_addr, if_rdata;
    logic             dm_req, dm_we, dm_ready;
    logic [WIDTH-1:0] dm_addr, dm_wdata, dm_rdata;
    logic             mem_en, mem_we;
    logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
    logic             stall_f, stall_m;

    // ------------------------------------------------------------------
    // Instance B signals (MEM_LATENCY = 3)
    // ------------------------------------------------------------------
    logic             b_if_req, b_if_flush, b_if_ready;
    logic [WIDTH-1:0] b_if_addr, b_if_rdata;
    logic             b_dm_req, b_dm_we, b_dm_ready;
    logic [WIDTH-1:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic             b_mem_en, b_mem_we;
    logic [WIDTH-1:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic             b_stall_f, b_stall_m;

    mem_port_arbiter #(.WIDTH(WIDTH), .MEM_LATENCY(1), .MAX_DATA_BURST(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_f   (stall_f),
        .stall_m   (stall_m)
    );

    mem_port_arbiter #(.WIDTH(WIDTH), .MEM_LATENCY(3), .MAX_DATA_BURST(4)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .if_req    (b_if_req),
        .if_addr   (b_if_addr),
        .if_flush  (b_if_flush),
        .if_rdata  (b_if_rdata),
        .if_ready  (b_if_ready),
        .dm_req    (b_dm_req),
        .dm_we     (b_dm_we),
        .dm_addr   (b_dm_addr),
        .dm_wdata  (b_dm_wdata),
        .dm_rdata  (b_dm_rdata),
        .dm_ready  (b_dm_ready),
        .mem_en    (b_mem_en),
        .mem_we    (b_mem_we),
        .mem_addr  (b_mem_addr),
        .mem_wdata (b_mem_wdata),
        .mem_rdata (b_mem_rdata),
        .stall_f   (b_stall_f),
        .stall_m   (b_stall_m)
    );

    // Memory contents as a pure function of the address.
    function automatic logic [WIDTH-1:0] word_at(input logic [WIDTH-1:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {8'hC0, a[15:0], 8'h5A};
    endfunction

    // ------------------------------------------------------------------
    // Memory models: data is driven only in the cycle it is due
    // ------------------------------------------------------------------
    int unsigned      ma_cnt = 0;
    logic [WIDTH-1:0] ma_data = '0;
    int unsigned      mb_cnt = 0;
    logic [WIDTH-1:0] mb_data = '0;

    always @(posedge clk) begin
        if (mem_en) begin
            ma_cnt  <= 1;
            ma_data <= word_at(mem_addr);
        end else if (ma_cnt != 0) begin
            ma_cnt <= ma_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (b_mem_en) begin
            mb_cnt  <= 3;
            mb_data <= word_at(b_mem_addr);
        end else if (mb_cnt != 0) begin
            mb_cnt <= mb_cnt - 1;
        end
    end

    assign mem_rdata   = (ma_cnt == 1) ? ma_data : GARBAGE;
    assign b_mem_rdata = (mb_cnt == 1) ? mb_data : GARBAGE;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] exp_if_q[$];
    logic [WIDTH-1:0] exp_dm_q[$];
    logic [WIDTH-1:0] exp_b_if_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Every ready pulse pops one expected word and compares the read data.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (!rst) begin
            if (dm_ready) begin
                n_checks++;
                if (exp_dm_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dm_resp: unexpected dm_ready, dm_rdata=%h, no response expected", dm_rdata);
                end else begin
                    e = exp_dm_q.pop_front();
                    if (dm_rdata !== e) begin
                        n_fail++;
                        $display("FAIL dm_rdata: got %h expected %h", dm_rdata, e);
                    end
                end
            end
            if (if_ready) begin
                n_checks++;
                if (exp_if_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL if_resp: unexpected if_ready, if_rdata=%h, no response expected", if_rdata);
                end else begin
                    e = exp_if_q.pop_front();
                    if (if_rdata !== e) begin
                        n_fail++;
                        $display("FAIL if_rdata: got %h expected %h", if_rdata, e);
                    end
                end
            end
            if (b_if_ready) begin
                n_checks++;
                if (exp_b_if_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL lat3_if_resp: unexpected if_ready, if_rdata=%h", b_if_rdata);
                end else begin
                    e = exp_b_if_q.pop_front();
                    if (b_if_rdata !== e) begin
                        n_fail++;
                        $display("FAIL lat3_if_rdata: got %h expected %h", b_if_rdata, e);
                    end
                end
            end
        end
    end

    // Move to just after the next rising edge (start of the next cycle).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst        = 1'b1;
        if_req     = 1'b0; if_flush   = 1'b0; if_addr   = '0;
        dm_req     = 1'b0; dm_we      = 1'b0; dm_addr   = '0; dm_wdata   = '0;
        b_if_req   = 1'b0; b_if_flush = 1'b0; b_if_addr = '0;
        b_dm_req   = 1'b0; b_dm_we    = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got en/we/ifr/dmr=%b expected 0000",
                     {mem_en, mem_we, if_ready, dm_ready});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        n_checks++;
        if (if_rdata !== '0 || dm_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got if=%h dm=%h expected 0", if_rdata, dm_rdata);
        end
        n_checks++;
        if ({b_mem_en, b_if_ready, b_dm_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_lat3: got en/ifr/dmr=%b expected 000", {b_mem_en, b_if_ready, b_dm_ready});
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_load();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0100;
        exp_dm_q.push_back(32'hDEAD_BEEF);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_en !== (c == 1)) begin
                n_fail++;
                $display("FAIL load_mem_en c%0d: got %b expected %b", c, mem_en, (c == 1));
            end
            if (c == 1) begin
                n_checks++;
                if (mem_addr !== 32'h0000_0100 || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_issue: got addr=%h we=%b expected 00000100/0", mem_addr, mem_we);
                end
            end
            n_checks++;
            if (stall_m !== (c <= 2)) begin
                n_fail++;
                $display("FAIL load_stall_m c%0d: got %b expected %b", c, stall_m, (c <= 2));
            end
            n_checks++;
            if (dm_ready !== (c == 3)) begin
                n_fail++;
                $display("FAIL load_dm_ready c%0d: got %b expected %b", c, dm_ready, (c == 3));
            end
            next_cycle();
            if (c == 3) dm_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0000;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0200;
        dm_wdata = 32'h1234_5678;
        exp_dm_q.push_back(32'hDEAD_BEEF);   // store leaves load data untouched
        exp_if_q.push_back(word_at(32'h0000_0000));
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_en !== (c == 1 || c == 5)) begin
                n_fail++;
                $display("FAIL simul_mem_en c%0d: got %b expected %b", c, mem_en, (c == 1 || c == 5));
            end
            if (c == 1) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== 32'h0000_0200 || mem_wdata !== 32'h1234_5678) begin
                    n_fail++;
                    $display("FAIL simul_store_issue: got we=%b addr=%h wdata=%h expected 1/00000200/12345678",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (mem_we !== 1'b0 || mem_addr !== 32'h0000_0000) begin
                    n_fail++;
                    $display("FAIL simul_fetch_issue: got we=%b addr=%h expected 0/00000000", mem_we, mem_addr);
                end
            end
            n_checks++;
            if (dm_ready !== (c == 3) || if_ready !== (c == 7)) begin
                n_fail++;
                $display("FAIL simul_ready c%0d: got dm=%b if=%b expected dm=%b if=%b",
                         c, dm_ready, if_ready, (c == 3), (c == 7));
            end
            n_checks++;
            if (stall_f !== (c < 7)) begin
                n_fail++;
                $display("FAIL simul_stall_f c%0d: got %b expected %b", c, stall_f, (c < 7));
            end
            next_cycle();
            if (c == 3) begin dm_req = 1'b0; dm_we = 1'b0; end
            if (c == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_starvation();
        logic [WIDTH-1:0] exp_addr;
        int k;
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0300;
        for (int i = 0; i < 5; i++) exp_dm_q.push_back(word_at(32'h0000_0300));
        exp_if_q.push_back(word_at(32'h0000_0040));
        exp_if_q.push_back(word_at(32'h0000_0040));
        // Grants every 4 cycles: D D D D F D, then data drops and F again.
        for (int c = 0; c <= 27; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_en !== ((c % 4) == 1)) begin
                n_fail++;
                $display("FAIL starve_mem_en c%0d: got %b expected %b", c, mem_en, ((c % 4) == 1));
            end
            if ((c % 4) == 1) begin
                k        = c / 4;
                exp_addr = (k == 4 || k == 6) ? 32'h0000_0040 : 32'h0000_0300;
                n_checks++;
                if (mem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d: got addr=%h expected %h", k, mem_addr, exp_addr);
                end
            end
            next_cycle();
            if (c == 23) dm_req = 1'b0;
            if (c == 27) if_req = 1'b0;
        end
    endtask

    task automatic test_flush();
        // Flush during WAIT: access completes, ready suppressed, refetch 0x80.
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_en !== (c == 1 || c == 5)) begin
                n_fail++;
                $display("FAIL flush_mem_en c%0d: got %b expected %b", c, mem_en, (c == 1 || c == 5));
            end
            if (c == 5) begin
                n_checks++;
                if (mem_addr !== 32'h0000_0080) begin
                    n_fail++;
                    $display("FAIL flush_refetch_addr: got %h expected 00000080", mem_addr);
                end
            end
            n_checks++;
            if (if_ready !== (c == 7)) begin
                n_fail++;
                $display("FAIL flush_if_ready c%0d: got %b expected %b", c, if_ready, (c == 7));
            end
            next_cycle();
            if (c == 1) if_flush = 1'b1;
            if (c == 2) begin
                if_flush = 1'b0;
                if_addr  = 32'h0000_0080;
                exp_if_q.push_back(word_at(32'h0000_0080));
            end
            if (c == 7) if_req = 1'b0;
        end

        // Flush landing in RESP: if_ready forced low in that cycle.
        if_req  = 1'b1;
        if_addr = 32'h0000_000C;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (if_ready !== 1'b0 || mem_en !== (c == 1)) begin
                n_fail++;
                $display("FAIL flush_resp c%0d: got if_ready=%b mem_en=%b expected 0/%b",
                         c, if_ready, mem_en, (c == 1));
            end
            next_cycle();
            if (c == 2) if_flush = 1'b1;
            if (c == 3) begin if_flush = 1'b0; if_req = 1'b0; end
        end
    endtask

    task automatic test_async_reset();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0100;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (mem_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL areset_issue: got mem_en=%b expected 1", mem_en);
                end
            end
            if (c < 2) next_cycle();
        end
        // Now in WAIT, mid-cycle: pulse reset between edges.
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0000 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL areset_mem_bus: got en/we/ifr/dmr=%b addr=%h wdata=%h expected all 0",
                     {mem_en, mem_we, if_ready, dm_ready}, mem_addr, mem_wdata);
        end
        n_checks++;
        if (dm_rdata !== '0 || if_rdata !== '0) begin
            n_fail++;
            $display("FAIL areset_rdata: got dm=%h if=%h expected 0", dm_rdata, if_rdata);
        end
        dm_req = 1'b0;
        #1 rst = 1'b0;
        next_cycle();

        // Reissued load completes with normal latency.
        dm_req = 1'b1;
        exp_dm_q.push_back(32'hDEAD_BEEF);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (dm_ready !== (c == 3) || mem_en !== (c == 1)) begin
                n_fail++;
                $display("FAIL areset_reissue c%0d: got dm_ready=%b mem_en=%b expected %b/%b",
                         c, dm_ready, mem_en, (c == 3), (c == 1));
            end
            next_cycle();
            if (c == 3) dm_req = 1'b0;
        end
    endtask

    task automatic test_long_latency();
        b_if_req  = 1'b1;
        b_if_addr = 32'h0000_00C4;
        exp_b_if_q.push_back(word_at(32'h0000_00C4));
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (b_mem_en !== (c == 1)) begin
                n_fail++;
                $display("FAIL lat3_mem_en c%0d: got %b expected %b", c, b_mem_en, (c == 1));
            end
            n_checks++;
            if (b_if_ready !== (c == 5)) begin
                n_fail++;
                $display("FAIL lat3_if_ready c%0d: got %b expected %b", c, b_if_ready, (c == 5));
            end
            next_cycle();
            if (c == 5) b_if_req = 1'b0;
        end
    endtask

    task automatic test_drain();
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_if_q.size() != 0 || exp_dm_q.size() != 0 || exp_b_if_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: responses outstanding if=%0d dm=%0d lat3_if=%0d expected 0/0/0",
                     exp_if_q.size(), exp_dm_q.size(), exp_b_if_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_simultaneous();
        test_starvation();
        test_flush();
        test_async_reset();
        test_long_latency();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Sequences each access through a multi-cycle FSM: latch, issue, wait MEM_LATENCY, capture, respond.
- Drives per-requester ready pulses and stall outputs that are ORed into the hazard unit's StallF/StallD/stall-M paths.
- Data requests have priority; a starvation counter guarantees fetch progress. Fetch-side flush drops stale fetch results.

Parameters:
WIDTH, 32, data and address width
MEM_LATENCY, 1, cycles from mem_en cycle to mem_rdata valid (>=1)
MAX_DATA_BURST, 4, consecutive data grants allowed while fetch waits before fetch is forced to win

Ports:
clk  in  1  CPU clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch read request, held until if_ready or flush
if_addr  in  WIDTH  fetch byte address
if_flush  in  1  PCSrcE redirect; discards pending/in-flight fetch
if_rdata  out  WIDTH  fetched instruction, valid with if_ready
if_ready  out  1  one-cycle completion pulse to fetch
dm_req  in  1  data request, held until dm_ready
dm_we  in  1  1=store, 0=load
dm_addr  in  WIDTH  data byte address
dm_wdata  in  WIDTH  store data
dm_rdata  out  WIDTH  load data, valid with dm_ready
dm_ready  out  1  one-cycle completion pulse to memory stage
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, only with mem_en
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data
stall_f  out  1  if_req & ~if_ready (combinational)
stall_m  out  1  dm_req & ~dm_ready (combinational)

Behaviour:
- Reset (async, any state): state=IDLE, all mem_*/ready/rdata outputs=0, latency counter=0, burst counter=0, fetch-drop flag=0. An in-flight access is abandoned and gets no ready.
- States:
  - IDLE: arbitrate and latch the winner's addr/we/wdata. Go to ISSUE if any request is present, else stay in IDLE.
  - ISSUE: mem_en=1 for exactly this cycle, mem_we=latched we, mem_addr/mem_wdata=latched values. Load counter=MEM_LATENCY.
  - WAIT: decrement the counter. When it reaches 0, capture mem_rdata into the winner's rdata register and go to RESP.
  - RESP: winner's ready=1 for one cycle, then IDLE.
- Latency: request first sampled in IDLE at cycle 0 -> mem_en in cycle 1 -> ready in cycle 2+MEM_LATENCY. Throughput is one access per 3+MEM_LATENCY cycles. Requests sampled during RESP are ignored; arbitration happens only in IDLE.
- Arbitration in IDLE:
  - dm_req only -> data. if_req only -> fetch.
  - Both -> data, unless burst counter==MAX_DATA_BURST, then fetch.
- Burst counter:
  - Increments on each data grant made while if_req=1.
  - Clears on any fetch grant, and on any IDLE cycle where if_req=0.
  - Saturates at MAX_DATA_BURST.
- Flush:
  - if_flush in IDLE with if_req: fetch is not eligible that cycle.
  - if_flush during ISSUE/WAIT/RESP of a fetch: the memory access completes normally (timing unchanged), but if_ready is suppressed for that transaction (drop flag). If the flush lands in RESP, if_ready is forced to 0 that cycle.
  - Flush never affects data transactions.
- Stores: no data capture. dm_rdata holds its previous value; dm_ready pulses as for loads.
- rdata registers hold their value until the next capture for the same requester.
- Addresses pass through unmodified; alignment is checked upstream.
- mem_we=0 whenever mem_en=0.

Test Plan:
- Single load, MEM_LATENCY=1: dm_req=1, dm_we=0, dm_addr=0x100, memory returns 0xDEADBEEF -> mem_en pulse in cycle 1 with mem_addr=0x100; dm_ready=1 and dm_rdata=0xDEADBEEF in cycle 3; stall_m=1 in cycles 0-2.
- Simultaneous requests: if_req (0x0), dm_req store (0x200, 0x12345678) in cycle 0 -> store issued first (mem_we=1, mem_wdata=0x12345678); dm_ready in cycle 3; fetch issued in cycle 5, if_ready in cycle 7.
- Starvation, MAX_DATA_BURST=4: if_req held while dm_req is continuously re-asserted -> exactly 4 data grants, then a fetch grant, then data resumes.
- Flush mid-fetch: fetch 0x40 granted, if_flush=1 in the WAIT cycle -> mem_en still pulses once; if_ready stays 0; the FSM returns to IDLE on schedule; the next fetch to 0x80 completes normally.
- Async reset during WAIT of a load: rst pulsed between clock edges -> all outputs 0 immediately; dm_ready never pulses for the aborted load; a reissued load completes in 2+MEM_LATENCY cycles.
- MEM_LATENCY=3 sweep: single fetch -> if_ready in cycle 5; mem_rdata sampled only in the cycle the counter reaches 0 (memory model returns garbage in the earlier cycles).
